// File: rtl/mmio_sensor_hub.sv
// Memory-mapped hub for beam-break sensors: per-channel synchroniser, debounce,
// saturating coin-event counters, sticky pending flags and CPU output registers.
module mmio_sensor_hub #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DEBOUNCE = 16,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned NUM_OUT  = 6,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       sensor_in,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_wren,
    input  logic [31:0]             mem_wdata,
    output logic [31:0]             mem_rdata,
    output logic                    mmio_hit,
    output logic [32*NUM_OUT-1:0]   out_regs,
    output logic                    irq
);

    localparam int unsigned      DB_W    = $clog2(DEBOUNCE);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] sync1, sync2, deb;
    logic [DB_W-1:0]   db_cnt [NUM_CH];
    logic [NUM_CH-1:0] deb_flip, ev;
    logic [CNT_W-1:0]  count [NUM_CH];
    logic [NUM_CH-1:0] pending, pending_next, clr_pend;
    logic [31:0]       out_q [NUM_OUT];
    logic [4:0]        off;
    logic              wr, clr_cnt, clr_out;

    assign mmio_hit = ~|mem_addr[ADDR_W-1:5];
    assign off      = mem_addr[4:0];
    assign wr       = mem_wren & mmio_hit;
    assign clr_cnt  = wr && (off == 5'd31) && mem_wdata[0];
    assign clr_out  = wr && (off == 5'd31) && mem_wdata[1];
    assign clr_pend = (wr && (off == 5'd30)) ? mem_wdata[NUM_CH-1:0] : '0;

    // The event pulse fires on the same edge the debounced state falls,
    // so the count updates exactly 2+DEBOUNCE cycles after a raw edge.
    always_comb begin
        deb_flip = '0;
        ev       = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            deb_flip[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST);
            ev[i]       = deb_flip[i] & deb[i];
        end
    end

    assign pending_next = (pending & ~clr_pend) | ev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            for (int i = 0; i < int'(NUM_CH); i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= sensor_in;
            sync2 <= sync1;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (sync2[i] == deb[i] || deb_flip[i]) db_cnt[i] <= '0;
                else                                    db_cnt[i] <= db_cnt[i] + 1'b1;
                if (deb_flip[i]) deb[i] <= sync2[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) count[i] <= '0;
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (clr_cnt)                          count[i] <= CNT_W'(ev[i]);
                else if (ev[i] && count[i] != CNT_MAX) count[i] <= count[i] + 1'b1;
            end
            pending <= pending_next;
            irq     <= |pending_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(NUM_OUT); k++) out_q[k] <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_OUT); k++) begin
                if (clr_out)                          out_q[k] <= '0;
                else if (wr && off == 5'(16 + k))     out_q[k] <= mem_wdata;
            end
        end
    end

    always_comb begin
        out_regs = '0;
        for (int k = 0; k < int'(NUM_OUT); k++) out_regs[32*k +: 32] = out_q[k];
    end

    always_comb begin
        mem_rdata = '0;
        if (mmio_hit) begin
            for (int i = 0; i < int'(NUM_CH); i++)
                if (off == 5'(i)) mem_rdata = 32'(count[i]);
            if (off == 5'd8) mem_rdata[NUM_CH-1:0] = pending;
            if (off == 5'd9) mem_rdata[NUM_CH-1:0] = ~deb;
            for (int k = 0; k < int'(NUM_OUT); k++)
                if (off == 5'(16 + k)) mem_rdata = out_q[k];
        end
    end

endmodule

// File: tb/tb_mmio_sensor_hub.sv
// Directed bench for mmio_sensor_hub (CNT_W=4 so saturation is reachable).
module tb_mmio_sensor_hub;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [3:0]   sensor_in;
    logic [11:0]  mem_addr;
    logic         mem_wren;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mmio_hit;
    logic [191:0] out_regs;
    logic         irq;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0]  d;
    logic [191:0] exp_out;

    mmio_sensor_hub #(.NUM_CH(4), .DEBOUNCE(16), .CNT_W(4), .NUM_OUT(6), .ADDR_W(12)) dut (
        .clock(clock), .reset_n(reset_n), .sensor_in(sensor_in),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mmio_hit(mmio_hit), .out_regs(out_regs), .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        mem_addr = a;
        #1;
        v = mem_rdata;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] v);
        mem_addr  = a;
        mem_wdata = v;
        mem_wren  = 1'b1;
        tick(1);
        mem_wren  = 1'b0;
    endtask

    task automatic pulse(input int ch);
        sensor_in[ch] = 1'b0;
        tick(20);
        sensor_in[ch] = 1'b1;
        tick(20);
    endtask

    task automatic test_reset;
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", irq); end
        vectors++;
        if (out_regs !== '0) begin miscompares++; $display("FAIL reset_out_regs: got %h expected 0", out_regs); end
        for (int i = 0; i < 4; i++) begin
            rd(12'(i), d);
            vectors++;
            if (d !== 32'd0) begin miscompares++; $display("FAIL reset_count%0d: got %h expected 0", i, d); end
        end
        rd(12'd8, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL reset_pending: got %h expected 0", d); end
        rd(12'd9, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL reset_live: got %h expected 0", d); end
        vectors++;
        if (mmio_hit !== 1'b1) begin miscompares++; $display("FAIL reset_hit: got %b expected 1", mmio_hit); end
    endtask

    task automatic test_glitch;
        sensor_in[2] = 1'b0;
        tick(10);
        sensor_in[2] = 1'b1;
        tick(30);
        rd(12'd2, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL glitch_count: got %h expected 0", d); end
        rd(12'd8, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL glitch_pending: got %h expected 0", d); end
    endtask

    task automatic test_single_event;
        sensor_in[0] = 1'b0;
        tick(17);
        rd(12'd0, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL latency_early: got %h expected 0", d); end
        tick(1);
        rd(12'd0, d);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL latency_count: got %h expected 1", d); end
        rd(12'd8, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL single_pending: got %h expected 1", d); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL single_irq: got %b expected 1", irq); end
        rd(12'd9, d);
        vectors++;
        if (d !== 32'h1) begin miscompares++; $display("FAIL single_live: got %h expected 1", d); end
        sensor_in[0] = 1'b1;
        tick(25);
        rd(12'd9, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL release_live: got %h expected 0", d); end
        rd(12'd0, d);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL release_no_count: got %h expected 1", d); end
        wr(12'd30, 32'h1);
        rd(12'd8, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL w1c_pending: got %h expected 0", d); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL w1c_irq: got %b expected 0", irq); end
    endtask

    task automatic test_set_wins;
        pulse(1);
        pulse(1);
        rd(12'd1, d);
        vectors++;
        if (d !== 32'd2) begin miscompares++; $display("FAIL ch1_two: got %h expected 2", d); end
        wr(12'd30, 32'h2);
        rd(12'd8, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL ch1_cleared: got %h expected 0", d); end
        sensor_in[1] = 1'b0;
        tick(17);
        mem_addr  = 12'd30;
        mem_wdata = 32'h2;
        mem_wren  = 1'b1;
        tick(1);
        mem_wren  = 1'b0;
        rd(12'd1, d);
        vectors++;
        if (d !== 32'd3) begin miscompares++; $display("FAIL ch1_three: got %h expected 3", d); end
        rd(12'd8, d);
        vectors++;
        if (d !== 32'h2) begin miscompares++; $display("FAIL set_wins_pending: got %h expected 2", d); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL set_wins_irq: got %b expected 1", irq); end
        sensor_in[1] = 1'b1;
        tick(25);
        wr(12'd30, 32'hF);
    endtask

    task automatic test_multi;
        sensor_in[0] = 1'b0;
        sensor_in[2] = 1'b0;
        tick(18);
        rd(12'd0, d);
        vectors++;
        if (d !== 32'd2) begin miscompares++; $display("FAIL multi_ch0: got %h expected 2", d); end
        rd(12'd2, d);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL multi_ch2: got %h expected 1", d); end
        rd(12'd8, d);
        vectors++;
        if (d !== 32'h5) begin miscompares++; $display("FAIL multi_pending: got %h expected 5", d); end
        rd(12'd9, d);
        vectors++;
        if (d !== 32'h5) begin miscompares++; $display("FAIL multi_live: got %h expected 5", d); end
        sensor_in[0] = 1'b1;
        sensor_in[2] = 1'b1;
        tick(25);
        wr(12'd30, 32'hF);
    endtask

    task automatic test_saturate;
        for (int n = 0; n < 17; n++) pulse(3);
        rd(12'd3, d);
        vectors++;
        if (d !== 32'd15) begin miscompares++; $display("FAIL sat_count: got %h expected f", d); end
        rd(12'd8, d);
        vectors++;
        if (d !== 32'h8) begin miscompares++; $display("FAIL sat_pending: got %h expected 8", d); end
        wr(12'd30, 32'h8);
        pulse(3);
        rd(12'd3, d);
        vectors++;
        if (d !== 32'd15) begin miscompares++; $display("FAIL sat_hold: got %h expected f", d); end
        rd(12'd8, d);
        vectors++;
        if (d !== 32'h8) begin miscompares++; $display("FAIL sat_pending_again: got %h expected 8", d); end
        wr(12'd31, 32'h1);
        for (int i = 0; i < 4; i++) begin
            rd(12'(i), d);
            vectors++;
            if (d !== 32'd0) begin miscompares++; $display("FAIL clr_count%0d: got %h expected 0", i, d); end
        end
        sensor_in[3] = 1'b0;
        tick(17);
        mem_addr  = 12'd31;
        mem_wdata = 32'h1;
        mem_wren  = 1'b1;
        tick(1);
        mem_wren  = 1'b0;
        rd(12'd3, d);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL clr_with_event: got %h expected 1", d); end
        sensor_in[3] = 1'b1;
        tick(25);
    endtask

    task automatic test_out_regs;
        wr(12'd17, 32'hDEADBEEF);
        exp_out = '0;
        exp_out[63:32] = 32'hDEADBEEF;
        vectors++;
        if (out_regs !== exp_out) begin miscompares++; $display("FAIL out1_write: got %h expected %h", out_regs, exp_out); end
        rd(12'd17, d);
        vectors++;
        if (d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL out1_read: got %h expected deadbeef", d); end
        rd(12'd16, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL out0_read: got %h expected 0", d); end
        wr(12'd40, 32'h12345678);
        vectors++;
        if (out_regs !== exp_out) begin miscompares++; $display("FAIL addr40_write: got %h expected %h", out_regs, exp_out); end
        rd(12'd40, d);
        vectors++;
        if (mmio_hit !== 1'b0) begin miscompares++; $display("FAIL addr40_hit: got %b expected 0", mmio_hit); end
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL addr40_read: got %h expected 0", d); end
        rd(12'd12, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL unmapped_read: got %h expected 0", d); end
        wr(12'd21, 32'hA5A5_0F0F);
        rd(12'd21, d);
        vectors++;
        if (d !== 32'hA5A5_0F0F) begin miscompares++; $display("FAIL out5_read: got %h expected a5a50f0f", d); end
        wr(12'd31, 32'h2);
        vectors++;
        if (out_regs !== '0) begin miscompares++; $display("FAIL out_clear: got %h expected 0", out_regs); end
    endtask

    task automatic test_reset_mid;
        sensor_in[0] = 1'b0;
        tick(10);
        reset_n = 1'b0;
        rd(12'd3, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL async_reset_count: got %h expected 0", d); end
        tick(2);
        reset_n = 1'b1;
        tick(17);
        rd(12'd0, d);
        vectors++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL rst_mid_early: got %h expected 0", d); end
        tick(1);
        rd(12'd0, d);
        vectors++;
        if (d !== 32'd1) begin miscompares++; $display("FAIL rst_mid_count: got %h expected 1", d); end
        sensor_in[0] = 1'b1;
        tick(25);
    endtask

    initial begin
        reset_n   = 1'b0;
        sensor_in = 4'hF;
        mem_addr  = '0;
        mem_wren  = 1'b0;
        mem_wdata = '0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        test_reset;
        test_glitch;
        test_single_event;
        test_set_wins;
        test_multi;
        test_saturate;
        test_out_regs;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
